// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: AW-stage valid/ready shifter, stage k shifts by 2**k when amt[k]=1.
// Define BARREL_SHIFTER_ROTATE_EN to make mode 11 rotate right; otherwise mode 11 acts as LSR.
module pipelined_barrel_shifter #(
    parameter int W  = 8,
    parameter int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data
);
    logic          v [AW];
    logic          sg [AW];
    logic [W-1:0]  d [AW];
    logic [AW-1:0] a [AW];
    logic [1:0]    m [AW];
    logic          iv [AW];
    logic          isg [AW];
    logic [W-1:0]  id [AW];
    logic [AW-1:0] ia [AW];
    logic [1:0]    im [AW];
    logic          rdy [AW+1];
    logic          unused_tail;

    // Right shifts pull the fill word in from above: sign copies for ASR, the operand itself for ROR.
    function automatic logic [W-1:0] step(input logic [W-1:0] x, input logic [1:0] op,
                                          input logic s, input int n);
        logic [2*W-1:0] r;
`ifdef BARREL_SHIFTER_ROTATE_EN
        r = {op == 2'b11 ? x : {W{s & (op == 2'b10)}}, x} >> n;
`else
        r = {{W{s & (op == 2'b10)}}, x} >> n;
`endif
        return op == 2'b00 ? x << n : r[W-1:0];
    endfunction

    assign rdy[AW]     = out_ready;
    assign in_ready    = rdy[0];
    assign out_valid   = v[AW-1];
    assign out_data    = d[AW-1];
    assign unused_tail = ^{a[AW-1], m[AW-1], sg[AW-1]};

    for (genvar i = 0; i < AW; i++) begin : g_st
        if (i == 0) begin : g_src
            assign iv[i]  = in_valid;
            assign id[i]  = in_data;
            assign ia[i]  = in_amt;
            assign im[i]  = in_mode;
            assign isg[i] = in_data[W-1];
        end else begin : g_src
            assign iv[i]  = v[i-1];
            assign id[i]  = d[i-1];
            assign ia[i]  = a[i-1];
            assign im[i]  = m[i-1];
            assign isg[i] = sg[i-1];
        end
        assign rdy[i] = !v[i] || rdy[i+1];
        always_ff @(posedge clk) begin
            if (rst) begin
                v[i]  <= 1'b0;
                d[i]  <= '0;
                a[i]  <= '0;
                m[i]  <= '0;
                sg[i] <= 1'b0;
            end else if (rdy[i]) begin
                v[i] <= iv[i];
                if (iv[i]) begin
                    d[i]  <= ia[i][i] ? step(id[i], im[i], isg[i], 1 << i) : id[i];
                    a[i]  <= ia[i];
                    m[i]  <= im[i];
                    sg[i] <= isg[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: randomized and directed checks of pipelined_barrel_shifter (W=8)
// against a plain-arithmetic reference model and an in-order scoreboard.
module tb_pipelined_barrel_shifter;
    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;

    int            n_cmp = 0;
    int            n_err = 0;
    int            n_out = 0;
    logic [W-1:0]  exp_q[$];
    logic          stall_prev = 1'b0;
    logic [W-1:0]  held = '0;
`ifdef BARREL_SHIFTER_ROTATE_EN
    logic [W-1:0]  dir_exp [4] = '{8'hA0, 8'h16, 8'hF6, 8'h96};
`else
    logic [W-1:0]  dir_exp [4] = '{8'hA0, 8'h16, 8'hF6, 8'h16};
`endif

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input int n, input logic [1:0] md);
        logic [W-1:0] r;
        case (md)
            2'b00: r = x << n;
            2'b10: r = $signed(x) >>> n;
`ifdef BARREL_SHIFTER_ROTATE_EN
            2'b11: r = (x >> n) | (x << (W - n));
`endif
            default: r = x >> n;
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        in_amt   = AW'($urandom_range(W - 1, 0));
        in_mode  = 2'($urandom_range(3, 0));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, int'(in_amt), in_mode));
            if (stall_prev)
                check("hold", {out_valid, out_data}, {1'b1, held});
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0)
                    check("extra_out", 1, 0);
                else
                    check("data", out_data, exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            held = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int n0;
        int waited;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);

        for (int k = 0; k < 4; k++) begin
            int lat;
            lat = 0;
            in_valid = 1'b1;
            in_data  = 8'hB4;
            in_amt   = 3'd3;
            in_mode  = 2'(k);
            do begin
                tick;
                in_valid = 1'b0;
                lat++;
            end while (!out_valid && lat < 10);
            check("latency", lat, AW);
            check("mode_value", out_data, dir_exp[k]);
            tick;
        end

        n0 = n_out;
        for (int k = 0; k < 16; k++) begin
            drive_rand;
            check("stream_in_ready", in_ready, 1);
            tick;
        end
        in_valid = 1'b0;
        repeat (3) tick;
        check("stream_count", n_out - n0, 16);
        check("stream_empty", exp_q.size(), 0);

        out_ready = 1'b0;
        n0 = n_out;
        for (int k = 0; k < 3; k++) begin
            drive_rand;
            check("bp_fill_ready", in_ready, 1);
            tick;
        end
        for (int k = 0; k < 5; k++) begin
            drive_rand;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, exp_q.size() > 0 ? exp_q[0] : ~out_data);
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            tick;
            waited++;
        end
        check("bp_drained", exp_q.size(), 0);
        check("bp_count", n_out - n0, 3);

        drive_rand;
        tick;
        drive_rand;
        tick;
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        n0 = n_out;
        tick;
        check("mid_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        repeat (6) tick;
        check("mid_rst_no_out", n_out - n0, 0);

        for (int k = 0; k < 300; k++) begin
            drive_rand;
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = ($urandom_range(3, 0) != 0);
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            tick;
            waited++;
        end
        check("rand_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
